// File: rtl/row_collapser_if.sv
// Bus bundle for row_collapser: control handshake plus the 1R1W board memory port.
// Signal names follow the block's external naming; clk/rst_n remain plain ports.
interface row_collapser_if #(
  parameter int COLS = 10
);
  logic            start;
  logic            busy;
  logic            done;
  logic [4:0]      lines_cleared;
  logic            mem_rd_en;
  logic [4:0]      mem_rd_addr;
  logic [COLS-1:0] mem_rd_data;
  logic            mem_wr_en;
  logic [4:0]      mem_wr_addr;
  logic [COLS-1:0] mem_wr_data;

  modport slave (
    input  start, mem_rd_data,
    output busy, done, lines_cleared,
           mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data
  );

  modport master (
    output start, mem_rd_data,
    input  busy, done, lines_cleared,
           mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data
  );
endinterface

// File: rtl/row_collapser.sv
// Removes every full row from a board held in external 1R1W memory, shifting the
// rows above each removed row down by one and zero-filling the top row.
module row_collapser #(
  parameter int ROWS = 23,
  parameter int COLS = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  row_collapser_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, SCAN, SHIFT, CLEAR_TOP, DONE} state_t;

  localparam logic [4:0] TOP = 5'(ROWS - 1);

  state_t     r_state, w_state_nxt;
  logic [4:0] r_ptr, w_ptr_nxt;
  logic [4:0] r_dst, w_dst_nxt;
  logic [4:0] r_lines, w_lines_nxt;
  logic       r_cmp_valid;
  logic [4:0] r_cmp_addr;

  logic            w_rd_en, w_wr_en, w_busy, w_done, w_row_full;
  logic [4:0]      w_rd_addr, w_wr_addr;
  logic [COLS-1:0] w_wr_data;

  // r_cmp_valid/r_cmp_addr describe the read issued last cycle, whose data is on mem_rd_data now.
  assign w_row_full = r_cmp_valid && (&bus.mem_rd_data);

  // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_dst_nxt   = r_dst;
    w_lines_nxt = r_lines;
    w_rd_en     = 1'b0;
    w_rd_addr   = '0;
    w_wr_en     = 1'b0;
    w_wr_addr   = '0;
    w_wr_data   = '0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_lines_nxt = '0;
          w_ptr_nxt   = '0;
          w_state_nxt = SCAN;
        end
      end
      SCAN: begin
        w_busy = 1'b1;
        if (w_row_full) begin
          // Any read issued with this compare would be stale, so none is issued.
          w_dst_nxt   = r_cmp_addr;
          w_ptr_nxt   = r_cmp_addr + 5'd1;
          w_state_nxt = SHIFT;
        end else begin
          if (r_ptr <= TOP) begin
            w_rd_en   = 1'b1;
            w_rd_addr = r_ptr;
            w_ptr_nxt = r_ptr + 5'd1;
          end
          if (r_cmp_valid && r_cmp_addr == TOP) w_state_nxt = DONE;
        end
      end
      SHIFT: begin
        w_busy = 1'b1;
        if (r_ptr <= TOP) begin
          w_rd_en   = 1'b1;
          w_rd_addr = r_ptr;
          w_ptr_nxt = r_ptr + 5'd1;
        end
        // Write lands two rows below the concurrent read, keeping the memory simple 1R1W.
        if (r_cmp_valid) begin
          w_wr_en   = 1'b1;
          w_wr_addr = r_cmp_addr - 5'd1;
          w_wr_data = bus.mem_rd_data;
        end
        if (r_ptr > TOP) w_state_nxt = CLEAR_TOP;
      end
      CLEAR_TOP: begin
        w_busy      = 1'b1;
        w_wr_en     = 1'b1;
        w_wr_addr   = TOP;
        w_lines_nxt = r_lines + 5'd1;
        w_ptr_nxt   = r_dst;
        w_state_nxt = SCAN;
      end
      DONE: begin
        w_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_dst       <= '0;
      r_lines     <= '0;
      r_cmp_valid <= 1'b0;
      r_cmp_addr  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_dst       <= w_dst_nxt;
      r_lines     <= w_lines_nxt;
      r_cmp_valid <= w_rd_en;
      r_cmp_addr  <= w_rd_addr;
    end
  end

  assign bus.busy          = w_busy;
  assign bus.done          = w_done;
  assign bus.lines_cleared = r_lines;
  assign bus.mem_rd_en     = w_rd_en;
  assign bus.mem_rd_addr   = w_rd_addr;
  assign bus.mem_wr_en     = w_wr_en;
  assign bus.mem_wr_addr   = w_wr_addr;
  assign bus.mem_wr_data   = w_wr_data;

endmodule

// File: tb/tb_row_collapser.sv
// Scoreboard bench for row_collapser: a behavioural board model predicts the final
// board, line count and write count; a monitor compares on every done pulse.
module tb_row_collapser;
  localparam int ROWS = 23;
  localparam int COLS = 10;

  typedef logic [COLS-1:0] board_t [ROWS];
  typedef struct {
    int              lines;
    int              writes;
    logic [COLS-1:0] rows [ROWS];
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  row_collapser_if #(.COLS(COLS)) bus ();
  row_collapser #(.ROWS(ROWS), .COLS(COLS)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Board memory with one-cycle read latency; images are loaded through the same process.
  board_t mem;
  board_t load_img;
  bit     load_req = 1'b0;
  int     wr_cnt = 0, rd_cnt = 0;
  int     wr_base = 0, rd_base = 0;

  always @(posedge clk) begin
    if (load_req) mem <= load_img;
    else if (bus.mem_wr_en && bus.mem_wr_addr < ROWS) mem[bus.mem_wr_addr] <= bus.mem_wr_data;
    if (bus.mem_wr_en) wr_cnt <= wr_cnt + 1;
    if (bus.mem_rd_en) begin
      rd_cnt <= rd_cnt + 1;
      if (bus.mem_rd_addr < ROWS) bus.mem_rd_data <= mem[bus.mem_rd_addr];
      else bus.mem_rd_data <= 'x;
    end
  end

  // Reference: drop the lowest full row, append an empty row on top, repeat until none are full.
  function automatic exp_t model(input board_t b);
    exp_t e;
    logic [COLS-1:0] q[$];
    int k;
    e.lines  = 0;
    e.writes = 0;
    foreach (b[i]) q.push_back(b[i]);
    do begin
      k = -1;
      foreach (q[i]) if (k < 0 && q[i] == '1) k = i;
      if (k >= 0) begin
        e.writes += ROWS - k;
        q.delete(k);
        q.push_back('0);
        e.lines++;
      end
    end while (k >= 0);
    foreach (e.rows[i]) e.rows[i] = q[i];
    return e;
  endfunction

  exp_t sb_q[$];

  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        int bad;
        e = sb_q.pop_front();
        bad = 0;
        for (int i = 0; i < ROWS; i++) if (mem[i] !== e.rows[i]) bad++;
        check("lines_cleared", 32'(bus.lines_cleared), e.lines);
        check("board_rows_wrong", bad, 0);
        check("write_count", wr_cnt - wr_base, e.writes);
      end
    end
    if (bus.mem_rd_en && bus.mem_wr_en && bus.mem_rd_addr == bus.mem_wr_addr)
      check("rd_wr_same_addr", 32'(bus.mem_rd_addr), 32'hFFFF);
    if ((bus.mem_rd_en || bus.mem_wr_en) && !bus.busy)
      check("mem_access_not_busy", 1, 0);
  end

  task automatic load_board(input board_t b);
    @(negedge clk);
    load_img = b;
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  // Issues one operation, predicts its result, and watches it to completion.
  task automatic run_op(input bit poke, output int lat, output int dones, output int exp_lines);
    exp_t e;
    int busy_bad;
    e = model(mem);
    exp_lines = e.lines;
    sb_q.push_back(e);
    wr_base = wr_cnt;
    rd_base = rd_cnt;
    lat = -1;
    dones = 0;
    busy_bad = 0;
    @(negedge clk);
    bus.start = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      bus.start = poke && (i == 5 || i == 6);
      if (bus.done) begin
        lat = i + 1;
        dones++;
        check("busy_at_done", 32'(bus.busy), 0);
        break;
      end
      if (!bus.busy) busy_bad++;
    end
    bus.start = 1'b0;
    if (lat < 0) check("done_timeout", 0, 1);
    check("busy_during_op", busy_bad, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("lines_held", 32'(bus.lines_cleared), exp_lines);
  endtask

  function automatic board_t empty_board();
    board_t b;
    foreach (b[i]) b[i] = '0;
    return b;
  endfunction

  initial begin
    board_t b;
    int lat, dones, lines, seen;

    rst_n = 1'b0;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_rd_en", 32'(bus.mem_rd_en), 0);
    check("rst_wr_en", 32'(bus.mem_wr_en), 0);
    check("rst_lines", 32'(bus.lines_cleared), 0);
    check("rst_addrs", {bus.mem_rd_addr, bus.mem_wr_addr}, 0);
    check("rst_wr_data", 32'(bus.mem_wr_data), 0);
    rst_n = 1'b1;

    // Empty board: fixed latency and read count.
    load_board(empty_board());
    run_op(1'b0, lat, dones, lines);
    check("empty_latency", lat, 25);
    check("empty_reads", rd_cnt - rd_base, 23);
    check("empty_dones", dones, 1);

    // Bottom row full with a patterned row above it.
    b = empty_board();
    b[0] = '1;
    b[1] = 10'h155;
    load_board(b);
    run_op(1'b0, lat, dones, lines);
    check("row0_dones", dones, 1);

    // Two non-adjacent full rows.
    b = empty_board();
    b[3] = '1; b[5] = '1; b[4] = 10'h001; b[6] = 10'h200;
    load_board(b);
    run_op(1'b0, lat, dones, lines);
    check("r3r5_lines", lines, 2);

    // Only the top row full.
    b = empty_board();
    b[ROWS-1] = '1;
    load_board(b);
    run_op(1'b0, lat, dones, lines);
    check("top_lines", lines, 1);

    // Whole board full, with a start pulse while busy.
    foreach (b[i]) b[i] = '1;
    load_board(b);
    run_op(1'b1, lat, dones, lines);
    check("allfull_lines", lines, 23);
    check("allfull_single_done", dones, 1);

    // Reset during the second shift pass, then a normal run on the partial board.
    b = empty_board();
    b[0] = '1; b[5] = '1; b[8] = 10'h3A5; b[12] = 10'h0F0;
    load_board(b);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    seen = 0;
    for (int i = 0; i < 2000; i++) begin
      if (bus.lines_cleared == 5'd1 && bus.mem_wr_en && bus.mem_wr_addr != 5'(ROWS-1)) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    check("reach_second_shift", seen, 1);
    rst_n = 1'b0;
    wr_base = wr_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_wr_en", 32'(bus.mem_wr_en), 0);
    check("abort_lines", 32'(bus.lines_cleared), 0);
    repeat (4) @(negedge clk);
    check("abort_no_writes", wr_cnt - wr_base, 1);
    run_op(1'b0, lat, dones, lines);
    check("after_abort_dones", dones, 1);

    // Random boards.
    for (int t = 0; t < 20; t++) begin
      foreach (b[i]) b[i] = ($urandom_range(0, 2) == 0) ? '1 : COLS'($urandom);
      load_board(b);
      run_op(1'b0, lat, dones, lines);
      check("rand_dones", dones, 1);
    end

    check("scoreboard_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/row_collapser.md
ROW_COLLAPSER -- requirements
Module: row_collapser

Interface
REQ-001 SHALL have parameter ROWS, default 23, meaning the number of board rows; row 0 is the bottom row and row ROWS-1 the top row.
REQ-002 SHALL have parameter COLS, default 10, meaning the number of board columns; a row is full when all COLS bits are 1.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  the reset, which is synchronous and active-low.
REQ-005 SHALL have port start  input  1  the collapse request, sampled only in IDLE.
REQ-006 SHALL have port busy  output  1  high from the cycle after start is accepted until done.
REQ-007 SHALL have port done  output  1  a single-cycle pulse marking completion.
REQ-008 SHALL have port lines_cleared  output  5  the count of rows removed by the last completed operation.
REQ-009 SHALL have port mem_rd_en  output  1  the board read strobe.
REQ-010 SHALL have port mem_rd_addr  output  5  the board read row index.
REQ-011 SHALL have port mem_rd_data  input  COLS  the board read data, valid exactly 1 cycle after mem_rd_en.
REQ-012 SHALL have port mem_wr_en  output  1  the board write strobe.
REQ-013 SHALL have port mem_wr_addr  output  5  the board write row index.
REQ-014 SHALL have port mem_wr_data  output  COLS  the board write data.

Function
REQ-015 SHALL use states IDLE, SCAN, SHIFT, CLEAR_TOP and DONE.
REQ-016 IDLE: on start=1, SHALL clear lines_cleared to 0, set the scan pointer to 0 and enter SCAN; busy=1 from the next cycle.
REQ-017 SCAN: SHALL issue one read per cycle at addresses ptr, ptr+1, ... ROWS-1, with each returned row compared in the following cycle.
REQ-018 SCAN: on the first full row k, SHALL discard in-flight reads and enter SHIFT with dst=k; reads above k are not acted on.
REQ-019 SCAN: if row ROWS-1 compares not-full and no full row was found, SHALL enter DONE.
REQ-020 SHIFT: SHALL read row dst+1 in cycle c and write that data to row dst in cycle c+1, pipelined at one row per cycle, covering dst=k..ROWS-2.
REQ-021 SHIFT: SHALL never read and write the same address in the same cycle, so the memory need only be simple 1R1W.
REQ-022 CLEAR_TOP: SHALL write all-zero to row ROWS-1 for exactly one cycle, increment lines_cleared, then re-enter SCAN with ptr=k.
REQ-023 Rows below k are unchanged and known non-full, so they SHALL NOT be re-read.
REQ-024 Multiple full rows, adjacent or not, SHALL each be removed by repeated SHIFT/CLEAR_TOP passes; the final board contains no full row.
REQ-025 DONE: done=1 and busy=0 for one cycle, then IDLE.
REQ-026 lines_cleared SHALL hold its value until the next accepted start.
REQ-027 lines_cleared SHALL be 5 bits; maximum value ROWS (23), no overflow possible.
REQ-028 mem_rd_en and mem_wr_en SHALL be 0 in IDLE and DONE.
REQ-029 mem_wr_en SHALL be 1 only in SHIFT (delayed) and CLEAR_TOP.
REQ-030 start while busy SHALL be ignored, with no queuing.
REQ-031 start held high SHALL restart only after returning to IDLE.
REQ-032 If k=ROWS-1 (top row full), SHIFT SHALL perform no reads or writes and proceed directly to CLEAR_TOP.

Reset
REQ-033 rst_n=0 at a clock edge SHALL force IDLE, with busy, done, mem_rd_en, mem_wr_en and lines_cleared all 0, and addresses and write data 0.
REQ-034 Reset mid-operation SHALL abort immediately with no further writes; board contents are left as partially shifted; a new start is required.

Verification
REQ-035 Empty board, start at cycle 0: reads 0..22 in cycles 1..23, no writes, done=1 in cycle 25, lines_cleared=0.
REQ-036 Only row 0 full, row 1=0x155, others 0: final row 0=0x155, rows 1..22=0, lines_cleared=1, exactly 23 writes.
REQ-037 Rows 3 and 5 full, row 4=0x001, row 6=0x200: final row 3=0x001, row 4=0x200, rows 5..22=0, lines_cleared=2.
REQ-038 Only the top row (22) full: exactly one write (addr 22, data 0), lines_cleared=1.
REQ-039 All 23 rows full: final board all-zero, lines_cleared=23, done pulses once, and a second start during busy is ignored.
REQ-040 rst_n=0 asserted during SHIFT: next cycle busy=0, mem_wr_en=0, lines_cleared=0; a following start completes normally.
